nexus_push_arbiter: RTL and testbench
=====================================

Name: nexus_push_arbiter

Overview:
- Shares the single push port of the Nexus PIFO between TENANTS independent ingress requesters.
- Round-robin arbitration with per-tenant occupancy quotas enforces elastic SRAM sharing. No tenant can exceed its configured share or the total PIFO capacity.
- Sits directly in front of the PIFO push interface. It tracks occupancy from pop feedback and stamps the tenant ID into the pushed metadata.

Parameters:
- TENANTS, 4, number of requesters; power of 2, >=2
- PTW, 16, priority width
- MTW, 32, metadata width
- DEPTH, 1024, total PIFO element capacity
- CNT_W, 11, occupancy/quota counter width; must hold DEPTH
- TID_W, $clog2(TENANTS), tenant ID width (derived)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  TENANTS  per-tenant push request, held until acked
- i_req_data  in  TENANTS*(MTW+PTW)  per-tenant push word; tenant t occupies slice t
- o_ack  out  TENANTS  one-hot, combinational; request accepted this cycle
- i_hold  in  1  when high, no grants are issued
- o_push  out  1  registered push strobe to PIFO
- o_push_data  out  MTW+PTW  registered push word to PIFO
- i_pop_fire  in  1  PIFO popped one element this cycle
- i_pop_tenant  in  TID_W  tenant of popped element
- i_cfg_we  in  1  write quota
- i_cfg_tenant  in  TID_W  quota write / occupancy read index
- i_cfg_quota  in  CNT_W  new quota value
- o_cfg_occ  out  CNT_W  occupancy of i_cfg_tenant (combinational read)
- o_total_occ  out  CNT_W  registered sum of all occupancies
- o_full  out  1  o_total_occ == DEPTH
- o_err  out  1  sticky pop-underflow flag

Behaviour:

Reset and storage:
- On i_rst (sync, high): occ[t]=0 and quota[t]=DEPTH/TENANTS for all t; rr_ptr=TENANTS-1; o_push=0; o_push_data=0; o_total_occ=0; o_err=0.
- Reset mid-operation discards any in-flight push; o_push is 0 in the cycle after reset is sampled.

Arbitration and push:
- eligible[t] = i_req[t] && occ[t] < quota[t] && total_occ < DEPTH && !i_hold && !i_rst.
- Winner is the first eligible tenant searching rr_ptr+1, rr_ptr+2, ... modulo TENANTS. o_ack = onehot(winner), else 0. At most one ack per cycle.
- On a grant: rr_ptr <= winner. On the next edge o_push <= 1 and o_push_data <= winner's word with bits [MTW+PTW-1 -: TID_W] replaced by winner index. Latency is 1 cycle from ack to o_push.
- With no grant, o_push <= 0 and o_push_data holds its value. rr_ptr is unchanged when no grant.

Occupancy:
- Counters update at the grant edge (not the o_push edge), so there is no in-flight overcount.
- Grant to t: occ[t] += 1, total += 1.
- Valid pop of t (i_pop_fire && occ[t] > 0): occ[t] -= 1, total -= 1.
- Grant and pop of the same tenant in one cycle: occ[t] and total unchanged.
- Grant and pop of different tenants: each updated; total unchanged.
- Pop with occ[i_pop_tenant] == 0: ignored, counters unchanged, o_err <= 1 (sticky until reset).
- o_full reflects registered total; eligibility uses the same registered total.

Configuration:
- i_cfg_we writes quota[i_cfg_tenant] at the edge and takes effect on the next cycle's eligibility.
- Quota values above DEPTH are clamped to DEPTH.
- Lowering a quota below current occ drops nothing; that tenant is ineligible until occ drains below the new quota.
- quota=0 disables the tenant.

Test Plan:
Use TENANTS=4, DEPTH=16, CNT_W=5 (reset quota 4).

- Reset, then i_req=4'b1111 held for 4 cycles -> o_ack = 0001, 0010, 0100, 1000 in order; o_push high cycles 2-5; pushed words carry TIDs 0, 1, 2, 3; o_total_occ=4.
- Only tenant 2 requests for 6 cycles -> 4 acks then o_ack=0; occ[2]=4 read via o_cfg_occ; pop tenant 2 -> one more ack the following cycle.
- Write quota[0]=16, tenant 0 requests continuously -> 16 acks; o_full=1 on the cycle after the 16th grant; further requests from any tenant get no ack.
- Tenant 1 at occ=3: same cycle grant to tenant 1 and i_pop_fire with tenant 1 -> occ[1] stays 3, o_total_occ unchanged, o_push asserted next cycle.
- Pop tenant 3 with occ[3]=0 -> counters unchanged, o_err=1 and remains 1 until i_rst.
- Tenant 0 at occ=4: write quota[0]=2, then pop twice -> no ack to tenant 0 until occ=1; assert i_rst while o_ack active -> o_push=0 next cycle, all occ=0, next grant goes to tenant 0.

Source files
------------

// File: rtl/nexus_push_arbiter.sv
// Round-robin push arbiter in front of the Nexus PIFO. It enforces per-tenant
// occupancy quotas and the total capacity, and stamps the tenant ID into each pushed word.
module nexus_push_arbiter #(
  parameter  int TENANTS = 4,
  parameter  int PTW     = 16,
  parameter  int MTW     = 32,
  parameter  int DEPTH   = 1024,
  parameter  int CNT_W   = 11,
  localparam int TID_W   = $clog2(TENANTS),
  localparam int DW      = MTW + PTW
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [TENANTS-1:0]    i_req,
  input  logic [TENANTS*DW-1:0] i_req_data,
  output logic [TENANTS-1:0]    o_ack,
  input  logic                  i_hold,
  output logic                  o_push,
  output logic [DW-1:0]         o_push_data,
  input  logic                  i_pop_fire,
  input  logic [TID_W-1:0]      i_pop_tenant,
  input  logic                  i_cfg_we,
  input  logic [TID_W-1:0]      i_cfg_tenant,
  input  logic [CNT_W-1:0]      i_cfg_quota,
  output logic [CNT_W-1:0]      o_cfg_occ,
  output logic [CNT_W-1:0]      o_total_occ,
  output logic                  o_full,
  output logic                  o_err
);

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] RST_QUOTA_C = CNT_W'(DEPTH / TENANTS);

  logic [CNT_W-1:0]   occ_q   [TENANTS];
  logic [CNT_W-1:0]   occ_d   [TENANTS];
  logic [CNT_W-1:0]   quota_q [TENANTS];
  logic [CNT_W-1:0]   quota_d [TENANTS];
  logic [CNT_W-1:0]   total_q, total_d;
  logic [TID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               push_q, push_d;
  logic [DW-1:0]      push_data_q, push_data_d;
  logic               err_q, err_d;

  logic [TENANTS-1:0] eligible;
  logic [TENANTS-1:0] pop_vec;
  logic [TID_W-1:0]   search_idx;
  logic [TID_W-1:0]   winner;
  logic               grant;
  logic               pop_valid;
  logic               pop_err;
  logic               cap_full;
  logic [CNT_W-1:0]   cfg_quota_clamped;
  logic [DW-1:0]      push_word;

  assign cap_full = (total_q >= DEPTH_C);

  always_comb begin
    for (int t = 0; t < TENANTS; t++) begin
      eligible[t] = i_req[t] && (occ_q[t] < quota_q[t]) && !cap_full && !i_hold && !i_rst;
    end
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise an unassigned path infers a latch.
  always_comb begin
    grant      = 1'b0;
    winner     = '0;
    search_idx = '0;
    // The search starts one past the last winner; TID_W-bit addition wraps modulo TENANTS.
    for (int k = 1; k <= TENANTS; k++) begin
      search_idx = rr_ptr_q + TID_W'(k);
      if (!grant && eligible[search_idx]) begin
        grant  = 1'b1;
        winner = search_idx;
      end
    end
  end

  assign o_ack = grant ? (TENANTS'(1) << winner) : '0;

  always_comb begin
    push_word                 = i_req_data[int'(winner)*DW +: DW];
    push_word[DW-1 -: TID_W]  = winner;
  end

  assign pop_valid = i_pop_fire && (occ_q[i_pop_tenant] != '0);
  assign pop_err   = i_pop_fire && (occ_q[i_pop_tenant] == '0);
  assign pop_vec   = pop_valid ? (TENANTS'(1) << i_pop_tenant) : '0;

  // A grant and a pop on the same tenant cancel, so occupancy never counts in-flight words twice.
  always_comb begin
    occ_d = occ_q;
    for (int t = 0; t < TENANTS; t++) begin
      case ({o_ack[t], pop_vec[t]})
        2'b10:   occ_d[t] = occ_q[t] + 1'b1;
        2'b01:   occ_d[t] = occ_q[t] - 1'b1;
        default: occ_d[t] = occ_q[t];
      endcase
    end
  end

  always_comb begin
    case ({grant, pop_valid})
      2'b10:   total_d = total_q + 1'b1;
      2'b01:   total_d = total_q - 1'b1;
      default: total_d = total_q;
    endcase
  end

  assign cfg_quota_clamped = (i_cfg_quota > DEPTH_C) ? DEPTH_C : i_cfg_quota;

  always_comb begin
    quota_d = quota_q;
    if (i_cfg_we) begin
      quota_d[i_cfg_tenant] = cfg_quota_clamped;
    end
  end

  always_comb begin
    rr_ptr_d    = grant ? winner : rr_ptr_q;
    push_d      = grant;
    push_data_d = grant ? push_word : push_data_q;
    err_d       = err_q | pop_err;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the per-tenant counter and quota arrays are small flop arrays,
      // not SRAM, so they are reset explicitly to known values.
      for (int t = 0; t < TENANTS; t++) begin
        occ_q[t]   <= '0;
        quota_q[t] <= RST_QUOTA_C;
      end
      total_q     <= '0;
      rr_ptr_q    <= TID_W'(TENANTS - 1);
      push_q      <= 1'b0;
      push_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int t = 0; t < TENANTS; t++) begin
        occ_q[t]   <= occ_d[t];
        quota_q[t] <= quota_d[t];
      end
      total_q     <= total_d;
      rr_ptr_q    <= rr_ptr_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      err_q       <= err_d;
    end
  end

  assign o_push      = push_q;
  assign o_push_data = push_data_q;
  assign o_cfg_occ   = occ_q[i_cfg_tenant];
  assign o_total_occ = total_q;
  assign o_full      = (total_q == DEPTH_C);
  assign o_err       = err_q;

endmodule

// File: tb/tb_nexus_push_arbiter.sv
// Scoreboard bench for nexus_push_arbiter: directed scenarios followed by a
// randomized phase, each checked against an array-based quota/round-robin model.
module tb_nexus_push_arbiter;

  localparam int T     = 4;
  localparam int PTW   = 16;
  localparam int MTW   = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int TW    = 2;
  localparam int DW    = MTW + PTW;

  logic            clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [T-1:0]    i_req = '0;
  logic [T*DW-1:0] i_req_data = '0;
  logic [T-1:0]    o_ack;
  logic            i_hold = 1'b0;
  logic            o_push;
  logic [DW-1:0]   o_push_data;
  logic            i_pop_fire = 1'b0;
  logic [TW-1:0]   i_pop_tenant = '0;
  logic            i_cfg_we = 1'b0;
  logic [TW-1:0]   i_cfg_tenant = '0;
  logic [CW-1:0]   i_cfg_quota = '0;
  logic [CW-1:0]   o_cfg_occ;
  logic [CW-1:0]   o_total_occ;
  logic            o_full;
  logic            o_err;

  nexus_push_arbiter #(
    .TENANTS(T), .PTW(PTW), .MTW(MTW), .DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_data(i_req_data),
    .o_ack(o_ack), .i_hold(i_hold), .o_push(o_push), .o_push_data(o_push_data),
    .i_pop_fire(i_pop_fire), .i_pop_tenant(i_pop_tenant), .i_cfg_we(i_cfg_we),
    .i_cfg_tenant(i_cfg_tenant), .i_cfg_quota(i_cfg_quota), .o_cfg_occ(o_cfg_occ),
    .o_total_occ(o_total_occ), .o_full(o_full), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  bit            started = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] data_r[T];

  // Reference model: plain counts per tenant, total derived by summation.
  int m_occ[T];
  int m_quota[T];
  int m_rr;
  bit m_err;

  function automatic int m_total();
    int s = 0;
    for (int t = 0; t < T; t++) s += m_occ[t];
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [T-1:0] req, input bit hold, input bit pf, input int pt,
                     input bit we, input int ct, input int cq, input bit rst,
                     output logic [T-1:0] ack_o);
    int            win;
    bit            pop_ok;
    logic [T-1:0]  eack;
    logic [DW-1:0] w;
    @(negedge clk);
    for (int t = 0; t < T; t++) begin
      if (!req[t]) data_r[t] = DW'({$urandom(), $urandom()});
      i_req_data[t*DW +: DW] = data_r[t];
    end
    i_req        = req;
    i_hold       = hold;
    i_pop_fire   = pf;
    i_pop_tenant = TW'(pt);
    i_cfg_we     = we;
    i_cfg_tenant = TW'(ct);
    i_cfg_quota  = CW'(cq);
    i_rst        = rst;
    #1;
    win = -1;
    if (!rst && !hold && m_total() < DEPTH) begin
      for (int k = 1; k <= T; k++) begin
        int t;
        t = (m_rr + k) % T;
        if (win < 0 && req[t] && m_occ[t] < m_quota[t]) win = t;
      end
    end
    eack  = (win >= 0) ? T'(1 << win) : '0;
    ack_o = o_ack;
    check("ack", 64'(o_ack), 64'(eack));
    if (started) begin
      check("cfg_occ", 64'(o_cfg_occ), 64'(m_occ[ct]));
      check("total_occ", 64'(o_total_occ), 64'(m_total()));
      check("full", 64'(o_full), 64'(m_total() == DEPTH));
      check("err", 64'(o_err), 64'(m_err));
    end
    if (win >= 0) begin
      w = data_r[win];
      w[DW-1 -: TW] = TW'(win);
      exp_q.push_back(w);
    end
    @(posedge clk);
    if (rst) begin
      for (int t = 0; t < T; t++) begin
        m_occ[t]   = 0;
        m_quota[t] = DEPTH / T;
      end
      m_rr    = T - 1;
      m_err   = 1'b0;
      started = 1'b1;
    end else begin
      pop_ok = pf && (m_occ[pt] > 0);
      if (pf && !pop_ok) m_err = 1'b1;
      if (win >= 0) begin
        m_occ[win]++;
        m_rr = win;
      end
      if (pop_ok) m_occ[pt]--;
      if (we) m_quota[ct] = (cq > DEPTH) ? DEPTH : cq;
    end
  endtask

  logic [T-1:0] ack;

  task automatic do_reset();
    cyc('0, 0, 0, 0, 0, 0, 0, 1, ack);
  endtask

  task automatic req_only(input logic [T-1:0] r, input int ct);
    cyc(r, 0, 0, 0, 0, ct, 0, 0, ack);
  endtask

  task automatic pop_with(input logic [T-1:0] r, input int pt, input int ct);
    cyc(r, 0, 1, pt, 0, ct, 0, 0, ack);
  endtask

  // Monitor: every observed push must match the oldest expected word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (started && o_push) begin
        if (exp_q.size() == 0) check("push_unexpected", 64'(o_push), 64'(0));
        else check("push_data", 64'(o_push_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [T-1:0] r;
    for (int t = 0; t < T; t++) data_r[t] = '0;
    do_reset();
    do_reset();

    // Four simultaneous requesters served in round-robin order from tenant 0.
    for (int i = 0; i < 4; i++) begin
      req_only(4'b1111, 0);
      check("s1_ack_order", 64'(ack), 64'(1 << i));
    end
    #1 check("s1_total", 64'(o_total_occ), 64'(4));

    // Single tenant limited by its quota; a pop frees one slot.
    do_reset();
    for (int i = 0; i < 6; i++) req_only(4'b0100, 2);
    check("s2_ack_stopped", 64'(ack), 64'(0));
    #1 check("s2_occ2", 64'(o_cfg_occ), 64'(4));
    pop_with(4'b0100, 2, 2);
    req_only(4'b0100, 2);
    check("s2_ack_after_pop", 64'(ack), 64'(4'b0100));

    // Raised quota lets one tenant fill the whole capacity.
    do_reset();
    cyc('0, 0, 0, 0, 1, 0, DEPTH, 0, ack);
    for (int i = 0; i < 17; i++) req_only(4'b0001, 0);
    #1 check("s3_full", 64'(o_full), 64'(1));
    req_only(4'b1111, 0);
    check("s3_no_ack_full", 64'(ack), 64'(0));

    // Same-cycle grant and pop on tenant 1 leave occupancy unchanged.
    do_reset();
    for (int i = 0; i < 3; i++) req_only(4'b0010, 1);
    pop_with(4'b0010, 1, 1);
    check("s4_ack", 64'(ack), 64'(4'b0010));
    #1;
    check("s4_occ1", 64'(o_cfg_occ), 64'(3));
    check("s4_total", 64'(o_total_occ), 64'(3));
    check("s4_push", 64'(o_push), 64'(1));

    // Underflow pop is ignored and raises the sticky error.
    pop_with('0, 3, 3);
    #1 check("s5_err", 64'(o_err), 64'(1));
    for (int i = 0; i < 3; i++) req_only('0, 3);
    #1 check("s5_err_sticky", 64'(o_err), 64'(1));

    // Lowered quota blocks until occupancy drains; reset suppresses a pending grant.
    do_reset();
    for (int i = 0; i < 4; i++) req_only(4'b0001, 0);
    cyc(4'b0001, 0, 0, 0, 1, 0, 2, 0, ack);
    check("s6_ack_lowered", 64'(ack), 64'(0));
    for (int i = 0; i < 3; i++) begin
      pop_with(4'b0001, 0, 0);
      check("s6_ack_draining", 64'(ack), 64'(0));
    end
    req_only(4'b0001, 0);
    check("s6_ack_occ1", 64'(ack), 64'(4'b0001));
    cyc(4'b1111, 0, 0, 0, 0, 0, 0, 1, ack);
    check("s6_ack_in_reset", 64'(ack), 64'(0));
    #1 check("s6_push_after_reset", 64'(o_push), 64'(0));
    req_only(4'b1111, 0);
    check("s6_first_grant", 64'(ack), 64'(4'b0001));

    // Randomized traffic with held requests, pops, holds, quota writes and resets.
    r = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int t = 0; t < T; t++) if (!r[t] && ($urandom_range(2) == 0)) r[t] = 1'b1;
      cyc(r, ($urandom_range(7) == 0), ($urandom_range(2) == 0), int'($urandom_range(T-1)),
          ($urandom_range(19) == 0), int'($urandom_range(T-1)), int'($urandom_range(31)),
          ($urandom_range(199) == 0), ack);
      r = r & ~ack;
    end

    req_only('0, 0);
    req_only('0, 0);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
